// File: rtl/mux_pkg.sv
// Shared types and defaults for the two-input round-robin stream arbiter.
package mux_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way grant: a lone requester always wins, and prio breaks ties.
module rr_pick2 (
   input  logic valid0,
   input  logic valid1,
   input  logic prio,
   output logic grant,
   output logic any_grant
);

   // Grant decode from the two request lines and the tie-break pointer
   always_comb begin
      grant     = 1'b0;
      any_grant = 1'b0;
      case ({valid1, valid0})
         2'b01: begin
            grant     = 1'b0;
            any_grant = 1'b1;
         end
         2'b10: begin
            grant     = 1'b1;
            any_grant = 1'b1;
         end
         2'b11: begin
            grant     = prio;
            any_grant = 1'b1;
         end
         2'b00: begin
            grant     = 1'b0;
            any_grant = 1'b0;
         end
         default: begin
            grant     = 1'b0;
            any_grant = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin valid/ready arbiter feeding a single registered output stage;
// exports the select of the word currently held.
module mux2_rr_arbiter
   import mux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             sel
);

   arb_state_t       state_r;
   logic             prio_r;
   logic             grant_s;
   logic             any_grant_s;
   logic             load_en_s;
   logic             accept_s;
   logic [WIDTH-1:0] win_data_s;

   rr_pick2 u_pick (
      .valid0    (in0_valid),
      .valid1    (in1_valid),
      .prio      (prio_r),
      .grant     (grant_s),
      .any_grant (any_grant_s)
   );

   // The output stage can take a word when it is empty or being drained this cycle
   always_comb begin
      load_en_s = (state_r == EMPTY) | out_ready;
      accept_s  = load_en_s & any_grant_s;
      in0_ready = accept_s & ~grant_s & in0_valid;
      in1_ready = accept_s &  grant_s & in1_valid;
   end

   // Winner's word; only ever captured when that source is valid
   always_comb begin
      if (grant_s) begin
         win_data_s = in1_data;
      end else begin
         win_data_s = in0_data;
      end
   end

   // Output register FSM; prio moves only when a word is actually accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= EMPTY;
         prio_r    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         sel       <= 1'b0;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept_s) begin
                  state_r   <= FULL;
                  out_valid <= 1'b1;
                  out_data  <= win_data_s;
                  sel       <= grant_s;
                  prio_r    <= ~grant_s;
               end
            end
            FULL: begin
               if (accept_s) begin
                  state_r   <= FULL;
                  out_valid <= 1'b1;
                  out_data  <= win_data_s;
                  sel       <= grant_s;
                  prio_r    <= ~grant_s;
               end else if (out_ready) begin
                  state_r   <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state_r   <= EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed and random checks of mux2_rr_arbiter against a scoreboard and a
// behavioural model of the round-robin pointer and output occupancy.
module tb_mux2_rr_arbiter;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in0_valid, in1_valid, out_ready;
   logic [W-1:0] in0_data, in1_data;
   logic         in0_ready, in1_ready, out_valid, sel;
   logic [W-1:0] out_data;

   int           checks   = 0;
   int           failures = 0;
   logic [W:0]   sb_q[$];
   logic         m_full, m_prio, m_acc0, m_acc1;
   int           n0, n1;

   always #5 clk = ~clk;

   mux2_rr_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called with inputs already driven, shortly after a rising edge.
   task automatic tick();
      logic       load, g, any, e0, e1;
      logic [W:0] e;
      #4;
      load = !m_full || out_ready;
      any  = in0_valid || in1_valid;
      g    = (in0_valid && in1_valid) ? m_prio : in1_valid;
      e0   = load && any && !g && in0_valid;
      e1   = load && any &&  g && in1_valid;
      chk("in0_ready", {31'd0, in0_ready}, {31'd0, e0});
      chk("in1_ready", {31'd0, in1_ready}, {31'd0, e1});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      if (m_full && out_ready) begin
         chk("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_word", {23'd0, sel, out_data}, {23'd0, e});
         end
      end
      m_acc0 = e0;
      m_acc1 = e1;
      if (e0 || e1) begin
         sb_q.push_back({g, g ? in1_data : in0_data});
         m_prio = ~g;
         m_full = 1'b1;
      end else if (m_full && out_ready) begin
         m_full = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_sel", {31'd0, sel}, 32'd0);
      m_full = 1'b0;
      m_prio = 1'b0;
      sb_q.delete();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b0;
      in0_data  = 8'h00;
      in1_data  = 8'h00;
      m_full    = 1'b0;
      m_prio    = 1'b0;
      m_acc0    = 1'b0;
      m_acc1    = 1'b0;
      #3;
      chk("init_out_valid", {31'd0, out_valid}, 32'd0);
      chk("init_out_data", {24'd0, out_data}, 32'd0);
      chk("init_sel", {31'd0, sel}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Continuous contention: alternation starting with in0
      n0 = 0;
      n1 = 0;
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in0_data = 8'h10 + 8'(n0);
         in1_data = 8'h20 + 8'(n1);
         tick();
         if (m_acc0) n0++;
         if (m_acc1) n1++;
         chk("cont_data", {24'd0, out_data},
             (i % 2 == 0) ? 32'h10 + 32'(i / 2) : 32'h20 + 32'(i / 2));
         chk("cont_sel", {31'd0, sel}, 32'(i % 2));
      end

      // Lone in1 back-to-back, in0 data junk while invalid
      in0_valid = 1'b0;
      in0_data  = 8'hEE;
      in1_data  = 8'h33;
      tick();
      chk("single_33", {23'd0, sel, out_data}, {23'd0, 1'b1, 8'h33});
      in1_data = 8'h34;
      tick();
      chk("single_34", {23'd0, sel, out_data}, {23'd0, 1'b1, 8'h34});
      in0_valid = 1'b1;
      in0_data  = 8'h41;
      in1_data  = 8'h42;
      tick();
      chk("tie_after_in1", {23'd0, sel, out_data}, {23'd0, 1'b0, 8'h41});

      // Back-pressure: hold 55 for three cycles, then in1 wins the tie
      in1_valid = 1'b0;
      in0_data  = 8'h55;
      tick();
      chk("bp_load", {24'd0, out_data}, 32'h55);
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      in0_data  = 8'h66;
      in1_data  = 8'h77;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold", {23'd0, sel, out_data}, {23'd0, 1'b0, 8'h55});
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release", {23'd0, sel, out_data}, {23'd0, 1'b1, 8'h77});

      // Drain to empty: data and sel hold
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      tick();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_hold", {23'd0, sel, out_data}, {23'd0, 1'b1, 8'h77});
      tick();

      // Asynchronous reset while FULL
      in0_valid = 1'b1;
      in0_data  = 8'hA5;
      tick();
      chk("mid_load", {24'd0, out_data}, 32'hA5);
      in0_valid = 1'b0;
      out_ready = 1'b0;
      do_reset();

      // Random valid/ready traffic
      for (int i = 0; i < 400; i++) begin
         in0_valid = 1'($urandom_range(0, 1));
         in1_valid = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         in0_data  = 8'($urandom_range(0, 255));
         in1_data  = 8'($urandom_range(0, 255));
         tick();
      end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
      end
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
